// File: rtl/dino_motion_ctrl.sv
// Dino vertical motion controller: turns synchronised jump/duck buttons into a y position,
// hitbox height and sprite pose, stepping once per frame tick and freezing while game_over is high.
module dino_motion_ctrl #(
   parameter int GROUND_Y = 248,
   parameter int JUMP_VEL = 12,
   parameter int GRAVITY  = 1,
   parameter int MAX_FALL = 12,
   parameter int DUCK_H   = 16,
   parameter int LEG_DIV  = 6,
   parameter int JUMP_BIT = 5,
   parameter int DUCK_BIT = 6
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  controller_report,
   input  logic        frame_tick,
   input  logic        game_over,
   output logic [10:0] dino_y,
   output logic [5:0]  dino_h,
   output logic [2:0]  pose,
   output logic        airborne,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {S_RUN = 2'd0, S_JUMP = 2'd1, S_DUCK = 2'd2, S_DEAD = 2'd3} state_t;

   localparam logic [2:0]         POSE_JUMP = 3'd2;
   localparam logic [2:0]         POSE_DUCK = 3'd3;
   localparam logic [2:0]         POSE_DEAD = 3'd4;
   localparam logic signed [11:0] GROUND    = 12'(GROUND_Y);
   localparam logic signed [11:0] JUMP_Y0   = 12'(GROUND_Y - JUMP_VEL);
   localparam logic signed [7:0]  JUMP_V0   = 8'(GRAVITY - JUMP_VEL);
   localparam logic signed [7:0]  G_NORMAL  = 8'(GRAVITY);
   localparam logic signed [7:0]  G_FAST    = 8'(2 * GRAVITY);
   localparam logic signed [7:0]  V_MAX     = 8'(MAX_FALL);
   localparam logic [3:0]         LEG_LAST  = 4'(LEG_DIV - 1);
   localparam logic [10:0]        DUCK_Y    = 11'(GROUND_Y + 32 - DUCK_H);

   state_t              state_q, state_d;
   logic signed [11:0]  y_q, y_d, y_step;
   logic signed [7:0]   vel_q, vel_d, vel_g;
   logic [3:0]          cnt_q, cnt_d;
   logic                leg_q, leg_d;
   logic                req_q, req_d;
   logic [2:0]          jsync_q;
   logic [1:0]          dsync_q;
   logic                jump_rise, duck;
   logic [10:0]         dino_y_d;
   logic [5:0]          dino_h_d;
   logic [2:0]          pose_d;
   logic                unused_bits;

   assign unused_bits = ^controller_report;
   assign jump_rise   = jsync_q[1] & ~jsync_q[2];
   assign duck        = dsync_q[1];
   assign dbg_state   = state_q;

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      vel_d   = vel_q;
      cnt_d   = cnt_q;
      leg_d   = leg_q;
      req_d   = (req_q & ~frame_tick) | jump_rise;
      y_step  = y_q + {{4{vel_q[7]}}, vel_q};
      vel_g   = vel_q + (duck ? G_FAST : G_NORMAL);
      if (vel_g > V_MAX) vel_g = V_MAX;

      if (state_q == S_DEAD) begin
         req_d = 1'b0;
         if (!game_over) begin
            state_d = S_RUN;
            y_d     = GROUND;
            vel_d   = '0;
            cnt_d   = '0;
         end
      end else if (game_over) begin
         state_d = S_DEAD;
      end else if (frame_tick) begin
         case (state_q)
            S_JUMP: begin
               if (y_step >= GROUND) begin
                  y_d     = GROUND;
                  vel_d   = '0;
                  state_d = duck ? S_DUCK : S_RUN;
               end else begin
                  y_d   = (y_step < 0) ? 12'sd0 : y_step;
                  vel_d = vel_g;
               end
            end
            default: begin
               // Jump beats duck when both are pending on the same tick.
               if (req_q) begin
                  state_d = S_JUMP;
                  y_d     = JUMP_Y0;
                  vel_d   = JUMP_V0;
               end else if (state_q == S_DUCK) begin
                  if (!duck) state_d = S_RUN;
               end else if (duck) begin
                  state_d = S_DUCK;
               end else if (cnt_q == LEG_LAST) begin
                  cnt_d = '0;
                  leg_d = ~leg_q;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         endcase
      end

      // Outputs are registered from the next-state view so they move with the state.
      dino_y_d = (state_d == S_DUCK) ? DUCK_Y : y_d[10:0];
      dino_h_d = (state_d == S_DUCK) ? 6'(DUCK_H) : 6'd32;
      case (state_d)
         S_JUMP:  pose_d = POSE_JUMP;
         S_DUCK:  pose_d = POSE_DUCK;
         S_DEAD:  pose_d = POSE_DEAD;
         default: pose_d = {2'b00, leg_d};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_RUN;
         y_q      <= GROUND;
         vel_q    <= '0;
         cnt_q    <= '0;
         leg_q    <= 1'b0;
         req_q    <= 1'b0;
         jsync_q  <= '0;
         dsync_q  <= '0;
         dino_y   <= 11'(GROUND_Y);
         dino_h   <= 6'd32;
         pose     <= 3'd0;
         airborne <= 1'b0;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         vel_q    <= vel_d;
         cnt_q    <= cnt_d;
         leg_q    <= leg_d;
         req_q    <= req_d;
         jsync_q  <= {jsync_q[1:0], controller_report[JUMP_BIT]};
         dsync_q  <= {dsync_q[0], controller_report[DUCK_BIT]};
         dino_y   <= dino_y_d;
         dino_h   <= dino_h_d;
         pose     <= pose_d;
         airborne <= (state_d == S_JUMP);
      end
   end

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed bench for dino_motion_ctrl: jump arc, run animation, duck, fast-fall,
// double-jump rejection, game_over freeze and mid-jump reset.
module tb_dino_motion_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  controller_report = '0;
   logic        frame_tick = 1'b0;
   logic        game_over = 1'b0;
   logic [10:0] dino_y;
   logic [5:0]  dino_h;
   logic [2:0]  pose;
   logic        airborne;
   logic [1:0]  dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   // Hand-computed default jump arc, dino_y after ticks 1..25.
   localparam int JUMP_Y [25] = '{236, 225, 215, 206, 198, 191, 185, 180, 176, 173, 171, 170, 170,
                                  171, 173, 176, 180, 185, 191, 198, 206, 215, 225, 236, 248};
   // Arc with duck held (gravity 2 after the first step), ticks 1..13; tick 14 lands.
   localparam int FAST_Y [13] = '{236, 225, 216, 209, 204, 201, 200, 201, 204, 209, 216, 225, 236};

   always #10 clk = ~clk;

   dino_motion_ctrl dut (
      .clk(clk), .reset_n(reset_n), .controller_report(controller_report),
      .frame_tick(frame_tick), .game_over(game_over), .dino_y(dino_y), .dino_h(dino_h),
      .pose(pose), .airborne(airborne), .dbg_state(dbg_state)
   );

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      controller_report = '0;
      frame_tick = 1'b0;
      game_over = 1'b0;
      wait_cycles(2);
      reset_n = 1'b1;
      wait_cycles(2);
   endtask

   task automatic tick();
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
   endtask

   task automatic set_buttons(input logic jump, input logic dk);
      controller_report[5] = jump;
      controller_report[6] = dk;
      wait_cycles(4);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      wait_cycles(1);
      n_cmp++; if (dino_y !== 11'd248) begin n_bad++; $display("FAIL reset_y: got %0d want 248", dino_y); end
      n_cmp++; if (dino_h !== 6'd32) begin n_bad++; $display("FAIL reset_h: got %0d want 32", dino_h); end
      n_cmp++; if (pose !== 3'd0) begin n_bad++; $display("FAIL reset_pose: got %0d want 0", pose); end
      n_cmp++; if (airborne !== 1'b0) begin n_bad++; $display("FAIL reset_air: got %0d want 0", airborne); end
      do_reset();
   endtask

   task automatic test_run_anim();
      logic [2:0] exp_pose;
      do_reset();
      exp_pose = 3'd0;
      for (int t = 1; t <= 18; t++) begin
         tick();
         if (t % 6 == 0) exp_pose = (exp_pose == 3'd0) ? 3'd1 : 3'd0;
         n_cmp++;
         if (pose !== exp_pose) begin
            n_bad++; $display("FAIL run_pose t%0d: got %0d want %0d", t, pose, exp_pose);
         end
      end
   endtask

   task automatic test_duck();
      do_reset();
      set_buttons(1'b0, 1'b1);
      tick();
      n_cmp++; if (pose !== 3'd3) begin n_bad++; $display("FAIL duck_pose: got %0d want 3", pose); end
      n_cmp++; if (dino_h !== 6'd16) begin n_bad++; $display("FAIL duck_h: got %0d want 16", dino_h); end
      n_cmp++; if (dino_y !== 11'd264) begin n_bad++; $display("FAIL duck_y: got %0d want 264", dino_y); end
      set_buttons(1'b0, 1'b0);
      tick();
      n_cmp++; if (pose !== 3'd0) begin n_bad++; $display("FAIL unduck_pose: got %0d want 0", pose); end
      n_cmp++; if (dino_h !== 6'd32) begin n_bad++; $display("FAIL unduck_h: got %0d want 32", dino_h); end
      n_cmp++; if (dino_y !== 11'd248) begin n_bad++; $display("FAIL unduck_y: got %0d want 248", dino_y); end
   endtask

   task automatic test_jump();
      do_reset();
      set_buttons(1'b1, 1'b0);
      set_buttons(1'b0, 1'b0);
      for (int t = 1; t <= 25; t++) begin
         tick();
         n_cmp++;
         if (dino_y !== 11'(JUMP_Y[t-1])) begin
            n_bad++; $display("FAIL jump_y t%0d: got %0d want %0d", t, dino_y, JUMP_Y[t-1]);
         end
         n_cmp++;
         if (airborne !== (t < 25)) begin
            n_bad++; $display("FAIL jump_air t%0d: got %0d want %0d", t, airborne, (t < 25));
         end
      end
      n_cmp++; if (pose !== 3'd0) begin n_bad++; $display("FAIL land_pose: got %0d want 0", pose); end
   endtask

   task automatic test_fast_fall();
      do_reset();
      set_buttons(1'b1, 1'b1);
      for (int t = 1; t <= 13; t++) begin
         tick();
         n_cmp++;
         if (dino_y !== 11'(FAST_Y[t-1]) || pose !== 3'd2) begin
            n_bad++; $display("FAIL fast_y t%0d: got y=%0d pose=%0d want y=%0d pose=2",
                              t, dino_y, pose, FAST_Y[t-1]);
         end
      end
      tick();
      n_cmp++; if (airborne !== 1'b0) begin n_bad++; $display("FAIL fast_land_air: got %0d want 0", airborne); end
      n_cmp++; if (pose !== 3'd3) begin n_bad++; $display("FAIL fast_land_pose: got %0d want 3", pose); end
      n_cmp++; if (dino_y !== 11'd264) begin n_bad++; $display("FAIL fast_land_y: got %0d want 264", dino_y); end
      n_cmp++; if (dbg_state !== 2'd2) begin n_bad++; $display("FAIL fast_land_state: got %0d want 2", dbg_state); end
      set_buttons(1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_buttons(1'b1, 1'b0);
      set_buttons(1'b0, 1'b0);
      for (int t = 1; t <= 27; t++) begin
         if (t == 5) set_buttons(1'b1, 1'b0);
         if (t == 6) set_buttons(1'b0, 1'b0);
         if (t == 20) set_buttons(1'b1, 1'b0);
         tick();
         n_cmp++;
         if (dino_y !== 11'((t <= 25) ? JUMP_Y[t-1] : 248) || airborne !== (t < 25)) begin
            n_bad++; $display("FAIL dbl_jump t%0d: got y=%0d air=%0d want y=%0d air=%0d", t, dino_y,
                              airborne, (t <= 25) ? JUMP_Y[t-1] : 248, (t < 25));
         end
      end
      set_buttons(1'b0, 1'b0);
   endtask

   task automatic test_game_over();
      do_reset();
      set_buttons(1'b1, 1'b0);
      set_buttons(1'b0, 1'b0);
      for (int t = 1; t <= 6; t++) tick();
      @(negedge clk) game_over = 1'b1;
      @(negedge clk);
      n_cmp++; if (pose !== 3'd4) begin n_bad++; $display("FAIL dead_pose: got %0d want 4", pose); end
      n_cmp++; if (dino_y !== 11'd191) begin n_bad++; $display("FAIL dead_y: got %0d want 191", dino_y); end
      n_cmp++; if (airborne !== 1'b0) begin n_bad++; $display("FAIL dead_air: got %0d want 0", airborne); end
      for (int t = 0; t < 3; t++) tick();
      n_cmp++;
      if (dino_y !== 11'd191 || pose !== 3'd4) begin
         n_bad++; $display("FAIL dead_hold: got y=%0d pose=%0d want y=191 pose=4", dino_y, pose);
      end
      @(negedge clk) game_over = 1'b0;
      @(negedge clk);
      n_cmp++; if (dino_y !== 11'd248) begin n_bad++; $display("FAIL revive_y: got %0d want 248", dino_y); end
      n_cmp++; if (pose !== 3'd0) begin n_bad++; $display("FAIL revive_pose: got %0d want 0", pose); end
      tick();
      n_cmp++;
      if (dino_y !== 11'd248 || airborne !== 1'b0) begin
         n_bad++; $display("FAIL revive_tick: got y=%0d air=%0d want y=248 air=0", dino_y, airborne);
      end
   endtask

   task automatic test_reset_mid_jump();
      do_reset();
      set_buttons(1'b1, 1'b0);
      set_buttons(1'b0, 1'b0);
      for (int t = 1; t <= 5; t++) tick();
      n_cmp++; if (dino_y !== 11'd198) begin n_bad++; $display("FAIL pre_rst_y: got %0d want 198", dino_y); end
      #3 reset_n = 1'b0;
      #1;
      n_cmp++; if (dino_y !== 11'd248) begin n_bad++; $display("FAIL rst_mid_y: got %0d want 248", dino_y); end
      n_cmp++;
      if (airborne !== 1'b0 || pose !== 3'd0 || dino_h !== 6'd32) begin
         n_bad++; $display("FAIL rst_mid_out: got air=%0d pose=%0d h=%0d want 0 0 32", airborne, pose, dino_h);
      end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_run_anim();
      test_duck();
      test_jump();
      test_fast_fall();
      test_back_to_back();
      test_game_over();
      test_reset_mid_jump();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
